// File: rtl/lisnoc_packetizer_prio.sv
// lisnoc_packetizer_prio
//   Injection-side packet builder for a LISNoC network interface. Takes a
//   packet descriptor plus a payload word stream from the core and emits a
//   HEADER/PAYLOAD.../LAST (or SINGLE) flit sequence into a router input port.
//   The header carries a priority field {prio_en, prio} that the router output
//   arbiters decode.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   req_*_i / req_ready_o      descriptor handshake (dest, prio, length, user header bits)
//   data_valid_i/data_ready_o  payload word handshake, data_i = payload word
//   flit_o/valid_o/ready_i     registered flit output {type, data} to the router
//   busy_o                     packet in progress or a flit still held on the link
//   pkt_count_o                packets fully sent (LAST/SINGLE transferred), wraps
module lisnoc_packetizer_prio #(
  parameter int flit_data_width = 32,
  parameter int flit_type_width = 2,
  parameter int dest_width      = 5,
  parameter int ph_prio_width   = 4,
  parameter int ph_prio_offset  = 5,
  parameter int len_width       = 8,
  localparam int flit_width     = flit_data_width + flit_type_width,
  localparam int hdr_width      = flit_data_width - dest_width - ph_prio_width
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [dest_width-1:0]      req_dest_i,
  input  logic                       req_prio_en_i,
  input  logic [ph_prio_width-2:0]   req_prio_i,
  input  logic [len_width-1:0]       req_len_i,
  input  logic [hdr_width-1:0]       req_hdr_i,
  input  logic                       data_valid_i,
  output logic                       data_ready_o,
  input  logic [flit_data_width-1:0] data_i,
  output logic [flit_width-1:0]      flit_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic                       busy_o,
  output logic [15:0]                pkt_count_o
);

  localparam logic [flit_type_width-1:0] TYPE_PAYLOAD = flit_type_width'(0);
  localparam logic [flit_type_width-1:0] TYPE_HEADER  = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] TYPE_LAST    = flit_type_width'(2);
  localparam logic [flit_type_width-1:0] TYPE_SINGLE  = flit_type_width'(3);

  // MSB of the priority field (the prio-enable bit)
  localparam int PRIO_MSB = flit_data_width - ph_prio_offset - 1;

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t                    state_q, state_d;
  logic [flit_width-1:0]     flit_q, flit_d;
  logic                      valid_q, valid_d;
  logic [len_width-1:0]      rem_q, rem_d;
  logic [15:0]               cnt_q, cnt_d;
  logic [flit_data_width-1:0] hdr_data;
  logic [flit_type_width-1:0] held_type;
  logic                      can_load;

  // Output register may take a new flit when empty or draining this cycle.
  assign can_load  = !valid_q || ready_i;
  assign held_type = flit_q[flit_width-1 -: flit_type_width];

  // Header assembly; prio value is zeroed when priority is disabled so the
  // arbiters never see stale bits.
  always_comb begin
    hdr_data = '0;
    hdr_data[flit_data_width-1 -: dest_width]   = req_dest_i;
    hdr_data[PRIO_MSB]                          = req_prio_en_i;
    hdr_data[PRIO_MSB-1 -: ph_prio_width-1]     = req_prio_en_i ? req_prio_i : '0;
    hdr_data[PRIO_MSB-ph_prio_width:0]          = req_hdr_i;
  end

  always_comb begin
    state_d      = state_q;
    flit_d       = flit_q;
    valid_d      = valid_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    req_ready_o  = 1'b0;
    data_ready_o = 1'b0;

    // Drain the held flit; a tail flit completes a packet.
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
      if (held_type == TYPE_LAST || held_type == TYPE_SINGLE)
        cnt_d = cnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        req_ready_o = can_load && !rst;
        if (req_valid_i && req_ready_o) begin
          flit_d  = {(req_len_i == '0) ? TYPE_SINGLE : TYPE_HEADER, hdr_data};
          valid_d = 1'b1;
          rem_d   = req_len_i;
          if (req_len_i != '0)
            state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        data_ready_o = can_load && !rst;
        if (data_valid_i && data_ready_o) begin
          flit_d  = {(rem_q == len_width'(1)) ? TYPE_LAST : TYPE_PAYLOAD, data_i};
          valid_d = 1'b1;
          rem_d   = rem_q - len_width'(1);
          if (rem_q == len_width'(1))
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flit_q  <= '0;
      valid_q <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flit_o      = flit_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != IDLE) || valid_q;
  assign pkt_count_o = cnt_q;

endmodule

// File: tb/tb_lisnoc_packetizer_prio.sv
// Testbench for lisnoc_packetizer_prio: directed scenarios plus randomized
// packets and backpressure, checked against a flit-level scoreboard built from
// the packet format rules.
module tb_lisnoc_packetizer_prio;

  localparam logic [1:0] T_PAY = 2'b00, T_HDR = 2'b01, T_LAST = 2'b10, T_SGL = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [4:0]  req_dest_i = '0;
  logic        req_prio_en_i = 1'b0;
  logic [2:0]  req_prio_i = '0;
  logic [7:0]  req_len_i = '0;
  logic [22:0] req_hdr_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] data_i = '0;
  logic [33:0] flit_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic        busy_o;
  logic [15:0] pkt_count_o;

  lisnoc_packetizer_prio dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_dest_i(req_dest_i), .req_prio_en_i(req_prio_en_i), .req_prio_i(req_prio_i),
    .req_len_i(req_len_i), .req_hdr_i(req_hdr_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
    .flit_o(flit_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ready_i driver: fixed value or random backpressure
  bit rdy_rand = 1'b0;
  bit rdy_val  = 1'b1;
  always @(posedge clk) begin
    #2;
    ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Reference model: expected flit stream and packet count
  logic [33:0] exp_q[$];
  logic [15:0] exp_cnt = '0;
  logic [31:0] pl[$];
  int cyc = 0, first_cyc = 0, last_cyc = 0, n_xfer = 0, n_last = 0;
  int trk_epoch = 0, seen_epoch = 0;
  logic [33:0] first_flit = '0, last_flit = '0, hold_flit = '0;
  bit hold = 1'b0;

  always @(negedge clk) begin
    logic [33:0] e;
    cyc++;
    if (trk_epoch != seen_epoch) begin
      seen_epoch = trk_epoch;
      n_xfer = 0;
      n_last = 0;
    end
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
      hold = 1'b0;
    end else begin
      chk("pkt_count", pkt_count_o, exp_cnt);
      if (hold) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_flit", flit_o, hold_flit);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) chk("extra_flit", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("flit", flit_o, e);
          if (e[33:32] == T_LAST || e[33:32] == T_SGL) exp_cnt++;
        end
        if (n_xfer == 0) begin first_cyc = cyc; first_flit = flit_o; end
        last_cyc = cyc;
        last_flit = flit_o;
        n_xfer++;
        if (flit_o[33:32] == T_LAST) n_last++;
      end
      hold = valid_o && !ready_i;
      hold_flit = flit_o;
    end
  end

  task automatic req_hs();
    bit acc = 1'b0;
    int to = 0;
    req_valid_i = 1'b1;
    while (!acc) begin
      @(negedge clk); acc = req_ready_o;
      @(posedge clk); #1;
      to++;
      if (!acc && to > 2000) begin chk("req_timeout", 0, 1); break; end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic data_hs(input logic [31:0] w);
    bit acc = 1'b0;
    int to = 0;
    data_valid_i = 1'b1;
    data_i = w;
    while (!acc) begin
      @(negedge clk); acc = data_ready_o;
      @(posedge clk); #1;
      to++;
      if (!acc && to > 2000) begin chk("data_timeout", 0, 1); break; end
    end
    data_valid_i = 1'b0;
  endtask

  function automatic logic [31:0] hdr_word(input logic [4:0] d, input logic en,
                                           input logic [2:0] p, input logic [22:0] h);
    return {d, en, (en ? p : 3'd0), h};
  endfunction

  // Sends one packet; payload words come from pl (must hold len entries).
  task automatic send_pkt(input logic [4:0] d, input logic en, input logic [2:0] p,
                          input logic [7:0] len, input logic [22:0] h, input int gap);
    exp_q.push_back({(len == 0) ? T_SGL : T_HDR, hdr_word(d, en, p, h)});
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({(i == int'(len) - 1) ? T_LAST : T_PAY, pl[i]});
    req_dest_i = d; req_prio_en_i = en; req_prio_i = p; req_len_i = len; req_hdr_i = h;
    req_hs();
    for (int i = 0; i < int'(len); i++) begin
      while ($urandom_range(0, 99) < gap) begin
        @(posedge clk); #1;
      end
      data_hs(pl[i]);
    end
  endtask

  task automatic fill_rand(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back($urandom);
  endtask

  task automatic drain();
    int to = 0;
    while ((busy_o || exp_q.size() != 0) && to < 3000) begin
      @(negedge clk); to++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] base;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_o, 0);
    chk("rst_flit", flit_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_data_ready", data_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_count", pkt_count_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single-flit packet with priority
    trk_epoch++;
    pl.delete();
    send_pkt(5'd3, 1'b1, 3'd5, 8'd0, 23'd0, 0);
    drain();
    chk("t1_nflits", n_xfer, 1);
    chk("t1_type", last_flit[33:32], T_SGL);
    chk("t1_dest", last_flit[31:27], 5'd3);
    chk("t1_prio", last_flit[26:23], 4'b1101);
    chk("t1_count", pkt_count_o, 1);
    chk("t1_busy", busy_o, 0);

    // 2: three payload words, priority disabled
    trk_epoch++;
    pl.delete(); pl.push_back(32'hA); pl.push_back(32'hB); pl.push_back(32'hC);
    send_pkt(5'd9, 1'b0, 3'd7, 8'd3, 23'h12345, 0);
    drain();
    chk("t2_nflits", n_xfer, 4);
    chk("t2_span", last_cyc - first_cyc, 3);
    chk("t2_hdr_prio", first_flit[26:23], 4'b0000);
    chk("t2_last", last_flit, {T_LAST, 32'hC});
    chk("t2_count", pkt_count_o, 2);

    // 3: backpressure while 0xB is held
    pl.delete(); pl.push_back(32'hA); pl.push_back(32'hB); pl.push_back(32'hC);
    fork
      send_pkt(5'd1, 1'b1, 3'd2, 8'd3, 23'h1, 0);
      begin
        int to = 0;
        do begin @(negedge clk); to++; end
        while (!(valid_o && flit_o == {T_PAY, 32'hA}) && to < 100);
        rdy_val = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("t3_valid", valid_o, 1);
          chk("t3_flit", flit_o, {T_PAY, 32'hB});
          chk("t3_data_ready", data_ready_o, 0);
        end
        rdy_val = 1'b1;
      end
    join
    drain();

    // 4: back-to-back packets, no bubble
    trk_epoch++;
    base = exp_cnt;
    fill_rand(1);
    send_pkt(5'd4, 1'b1, 3'd1, 8'd1, 23'h7, 0);
    fill_rand(1);
    send_pkt(5'd5, 1'b0, 3'd3, 8'd1, 23'h8, 0);
    drain();
    chk("t4_nflits", n_xfer, 4);
    chk("t4_span", last_cyc - first_cyc, 3);
    chk("t4_count", pkt_count_o, base + 16'd2);

    // 5: reset mid-packet after the header
    trk_epoch++;
    exp_q.push_back({T_HDR, hdr_word(5'd6, 1'b1, 3'd6, 23'h55)});
    req_dest_i = 5'd6; req_prio_en_i = 1'b1; req_prio_i = 3'd6; req_len_i = 8'd4; req_hdr_i = 23'h55;
    req_hs();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_req_ready_rst", req_ready_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", valid_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_count", pkt_count_o, 0);
    chk("t5_req_ready", req_ready_o, 1);
    chk("t5_nflits", n_xfer, 1);
    @(posedge clk); #1;
    trk_epoch++;
    pl.delete();
    send_pkt(5'd2, 1'b0, 3'd4, 8'd0, 23'h3, 0);
    drain();
    chk("t5_single", last_flit, {T_SGL, hdr_word(5'd2, 1'b0, 3'd4, 23'h3)});
    chk("t5_count_after", pkt_count_o, 1);

    // random packets with random backpressure and data gaps
    rdy_rand = 1'b1;
    for (int i = 0; i < 15; i++) begin
      int len;
      len = $urandom_range(0, 6);
      fill_rand(len);
      send_pkt(5'($urandom), 1'($urandom), 3'($urandom), 8'(len), 23'($urandom), 30);
    end
    drain();

    // 6: maximum length packet
    trk_epoch++;
    fill_rand(255);
    send_pkt(5'd31, 1'b1, 3'd7, 8'd255, 23'h7FFFFF, 30);
    drain();
    chk("t6_nflits", n_xfer, 256);
    chk("t6_nlast", n_last, 1);
    chk("t6_last", last_flit, {T_LAST, pl[254]});
    rdy_rand = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
